fifo_rd_packer: RTL and testbench

- Read-side consumer for the team's synchronous FIFO.
- Drives the FIFO pop interface (rd_en/dout/empty) and accounts for the FIFO's registered read data, which appears one cycle after rd_en.
- Packs PACK consecutive DATA_WIDTH-bit entries into one wide word and presents it on a valid/ready stream to the downstream datapath.
- A flush request emits a trailing partial word with a byte-lane keep mask.

---
 rtl/fifo_rd_packer_if.sv | 27 ++
 rtl/fifo_rd_packer.sv | 118 +++++++++++
 tb/tb_fifo_rd_packer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_packer_if.sv
// Bundles the FIFO pop side and the packed output stream of fifo_rd_packer.
// master: the packer itself; slave: the surrounding FIFO / downstream sink.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
);
    logic                         fifo_empty;
    logic [DATA_WIDTH-1:0]        fifo_dout;
    logic                         fifo_rd_en;
    logic                         flush;
    logic                         m_ready;
    logic                         m_valid;
    logic [PACK*DATA_WIDTH-1:0]   m_data;
    logic [PACK-1:0]              m_keep;
    logic                         m_last;
    logic                         flush_busy;

    modport master (
        input  fifo_empty, fifo_dout, flush, m_ready,
        output fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_busy
    );

    modport slave (
        output fifo_empty, fifo_dout, flush, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_busy
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops a synchronous FIFO (read data one cycle after rd_en), packs PACK
// entries per output word (first entry in lane 0) and streams the words out
// on valid/ready. A flush emits any trailing partial word with a keep mask.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic          clk,
    input  logic          rst,
    fifo_rd_packer_if.master bus
);
    localparam int             LW     = $clog2(PACK) + 1;
    localparam logic [LW-1:0]  PACK_L = LW'(PACK);

    logic [LW-1:0]                      lanes_q, lanes_d;
    logic                               inflight_q, inflight_d;
    logic [PACK-1:0][DATA_WIDTH-1:0]    acc_q, acc_d;
    logic                               m_valid_q, m_valid_d;
    logic [PACK*DATA_WIDTH-1:0]         m_data_q, m_data_d;
    logic [PACK-1:0]                    m_keep_q, m_keep_d;
    logic                               m_last_q, m_last_d;
    logic                               flush_busy_q, flush_busy_d;

    logic                               rd_en;
    logic                               out_free;
    logic                               emit_full;
    logic                               emit_flush;
    logic [PACK-1:0]                    keep_v;
    logic [PACK-1:0][DATA_WIDTH-1:0]    masked;

    // Pop only when a lane is guaranteed free for the entry (counting the one
    // already in flight); a pending or arriving flush stops new pops.
    always_comb begin
        rd_en = !rst && !bus.fifo_empty && !flush_busy_q && !bus.flush &&
                ((lanes_q + LW'(inflight_q)) < PACK_L);
    end

    // Capture, word transfer, flush emission and output-register handling.
    always_comb begin
        lanes_d      = lanes_q;
        inflight_d   = rd_en;
        acc_d        = acc_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        flush_busy_d = flush_busy_q;

        out_free = !m_valid_q || bus.m_ready;

        // Lanes at or above the fill level are zeroed; a full word keeps all.
        for (int i = 0; i < PACK; i++) begin
            keep_v[i] = (LW'(i) < lanes_q);
            masked[i] = keep_v[i] ? acc_q[i] : '0;
        end

        // A flush waits for the in-flight entry so it lands in the word.
        emit_flush = flush_busy_q && !inflight_q && out_free;
        emit_full  = !flush_busy_q && (lanes_q == PACK_L) && out_free;

        if (m_valid_q && bus.m_ready)
            m_valid_d = 1'b0;

        // inflight and a full accumulator are mutually exclusive, so capture
        // never collides with a transfer.
        if (inflight_q) begin
            for (int i = 0; i < PACK; i++)
                if (lanes_q == LW'(i))
                    acc_d[i] = bus.fifo_dout;
            lanes_d = lanes_q + 1'b1;
        end

        if (emit_full || (emit_flush && lanes_q != '0)) begin
            m_valid_d = 1'b1;
            m_data_d  = masked;
            m_keep_d  = keep_v;
            m_last_d  = emit_flush;
        end

        if (emit_full || emit_flush)
            lanes_d = '0;

        if (emit_flush)
            flush_busy_d = 1'b0;
        else if (bus.flush)
            flush_busy_d = 1'b1;
    end

    // State registers; reset discards partial and held data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q      <= '0;
            inflight_q   <= 1'b0;
            acc_q        <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            flush_busy_q <= 1'b0;
        end else begin
            lanes_q      <= lanes_d;
            inflight_q   <= inflight_d;
            acc_q        <= acc_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            flush_busy_q <= flush_busy_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_keep     = m_keep_q;
    assign bus.m_last     = m_last_q;
    assign bus.flush_busy = flush_busy_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-backed FIFO with registered read data
// feeds the DUT; a monitor compares every output beat with a queue of
// words built directly from the bytes pushed.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PK = 4;

    typedef struct {
        logic [PK*DW-1:0] d;
        logic [PK-1:0]    k;
        logic             l;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    logic [DW-1:0] fq[$];
    exp_t          exp_q[$];

    logic             hold_prev = 1'b0;
    logic [PK*DW-1:0] prev_data;
    logic [PK-1:0]    prev_keep;
    logic             prev_last;

    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, one cycle after rd_en.
    assign bus.fifo_empty = (fq.size() == 0);
    always @(posedge clk)
        if (bus.fifo_rd_en && fq.size() != 0)
            bus.fifo_dout <= fq.pop_front();

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [PK*DW-1:0] d, input logic [PK-1:0] k, input logic l);
        exp_t e;
        e.d = d; e.k = k; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        wait_cycles(1);
        bus.flush = 1'b0;
    endtask

    // Monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_rd_en", bus.fifo_rd_en, 0);
            check("rst_m_valid", bus.m_valid, 0);
            check("rst_m_keep", bus.m_keep, 0);
            check("rst_flush_busy", bus.flush_busy, 0);
            hold_prev = 1'b0;
        end else begin
            if (bus.fifo_empty)
                check("pop_when_empty", bus.fifo_rd_en, 0);
            if (bus.fifo_rd_en)
                pops++;
            if (hold_prev) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_data", bus.m_data, prev_data);
                check("hold_keep", bus.m_keep, prev_keep);
                check("hold_last", bus.m_last, prev_last);
            end
            if (bus.m_valid && bus.m_ready) begin
                check("beat_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat_data", bus.m_data, e.d);
                    check("beat_keep", bus.m_keep, e.k);
                    check("beat_last", bus.m_last, e.l);
                end
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            prev_keep = bus.m_keep;
            prev_last = bus.m_last;
        end
    end

    initial begin
        int p0;
        int n;
        int idx;
        int rem;
        logic [DW-1:0]    arr[$];
        logic [PK*DW-1:0] w;

        // Reset with a non-empty FIFO and ready downstream.
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b1;
        fq.push_back(8'h99);
        wait_cycles(5);
        fq.delete();
        rst = 1'b0;
        wait_cycles(2);

        // Single full word.
        p0 = pops;
        push_exp(32'h44332211, 4'hF, 1'b0);
        fq.push_back(8'h11); fq.push_back(8'h22);
        fq.push_back(8'h33); fq.push_back(8'h44);
        wait_cycles(12);
        check("single_pops", pops - p0, 4);
        check("single_drain", exp_q.size(), 0);

        // Backpressure: two words' worth fill output register and accumulator.
        p0 = pops;
        bus.m_ready = 1'b0;
        push_exp(32'h04030201, 4'hF, 1'b0);
        push_exp(32'h08070605, 4'hF, 1'b0);
        for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
        wait_cycles(20);
        check("bp_pops", pops - p0, 8);
        check("bp_valid", bus.m_valid, 1);
        check("bp_data", bus.m_data, 32'h04030201);
        check("bp_pending", exp_q.size(), 2);
        bus.m_ready = 1'b1;
        wait_cycles(15);
        check("bp_drain", exp_q.size(), 0);

        // Partial flush of two entries.
        push_exp(32'h0000BBAA, 4'h3, 1'b1);
        fq.push_back(8'hAA); fq.push_back(8'hBB);
        wait_cycles(6);
        pulse_flush();
        check("pf_busy", bus.flush_busy, 1);
        wait_cycles(4);
        check("pf_busy_clear", bus.flush_busy, 0);
        check("pf_drain", exp_q.size(), 0);

        // Empty FIFO: no pops; flush emits nothing and clears quickly.
        p0 = pops;
        wait_cycles(50);
        check("empty_pops", pops - p0, 0);
        pulse_flush();
        check("ef_busy", bus.flush_busy, 1);
        wait_cycles(1);
        check("ef_busy_clear", bus.flush_busy, 0);
        check("ef_no_valid", bus.m_valid, 0);
        wait_cycles(3);
        check("ef_no_beat", exp_q.size(), 0);

        // Reset in the middle of a word discards the partial accumulator.
        fq.push_back(8'h55); fq.push_back(8'h66);
        wait_cycles(5);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        push_exp(32'h13121110, 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) fq.push_back(DW'(8'h10 + i));
        wait_cycles(12);
        check("rst_mid_drain", exp_q.size(), 0);

        // Randomized traffic and backpressure, closed by a flush.
        n = $urandom_range(30, 45);
        for (int i = 0; i < n; i++) arr.push_back(DW'($urandom));
        for (int k = 0; k < n / PK; k++) begin
            w = '0;
            for (int i = 0; i < PK; i++) w |= (PK*DW)'(arr[k*PK+i]) << (DW*i);
            push_exp(w, '1, 1'b0);
        end
        rem = n % PK;
        if (rem != 0) begin
            w = '0;
            for (int i = 0; i < rem; i++) w |= (PK*DW)'(arr[(n/PK)*PK+i]) << (DW*i);
            push_exp(w, PK'((1 << rem) - 1), 1'b1);
        end
        idx = 0;
        while (idx < n) begin
            bus.m_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 1) == 1) begin
                fq.push_back(arr[idx]);
                idx++;
            end
            wait_cycles(1);
        end
        for (int i = 0; i < 30; i++) begin
            bus.m_ready = ($urandom_range(0, 99) < 60);
            wait_cycles(1);
        end
        bus.m_ready = 1'b1;
        wait_cycles(20);
        pulse_flush();
        wait_cycles(10);
        check("rand_drain", exp_q.size(), 0);
        check("rand_busy_clear", bus.flush_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
